// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative RV32M divide unit (DIV/DIVU/REM/REMU).
// Restoring division on operand magnitudes, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration loop.
module muldiv_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [1:0]            DivOp,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  Flush,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  quo;       // dividend shifts out the top, quotient shifts in the bottom
    logic [W-1:0]  rem;
    logic [W-1:0]  dvs;
    logic          is_rem;
    logic          neg_q;
    logic          neg_r;
    logic          special;
    logic [W-1:0]  spec_res;

    logic          signed_op, a_neg, b_neg, div_zero, ovf;
    logic [W-1:0]  a_abs, b_abs, spec_val, q_fix, r_fix;
    logic [W:0]    trial, diff;
    logic          ge;

    // Operand decode and special-case detection at capture time
    always_comb begin
        signed_op = ~DivOp[0];
        a_neg     = signed_op & SrcA[W-1];
        b_neg     = signed_op & SrcB[W-1];
        a_abs     = a_neg ? -SrcA : SrcA;
        b_abs     = b_neg ? -SrcB : SrcB;
        div_zero  = (SrcB == '0);
        ovf       = signed_op && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == {W{1'b1}});
        // Overflow quotient equals the dividend (most negative value)
        if (div_zero) spec_val = DivOp[1] ? SrcA : {W{1'b1}};
        else          spec_val = DivOp[1] ? '0   : SrcA;
    end

    // One restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        trial = {rem, quo[W-1]};
        diff  = trial - {1'b0, dvs};
        ge    = ~diff[W];
        q_fix = neg_q ? -quo : quo;
        r_fix = neg_r ? -rem : rem;
    end

    // Control FSM with registered Busy/Done/Result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            special  <= 1'b0;
            spec_res <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
        end else if (Flush) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Busy still high here means this is the Done cycle: Start is ignored
                    Done <= 1'b0;
                    Busy <= 1'b0;
                    if (Start && !Busy) begin
                        Busy     <= 1'b1;
                        cnt      <= '0;
                        quo      <= a_abs;
                        rem      <= '0;
                        dvs      <= b_abs;
                        is_rem   <= DivOp[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        special  <= div_zero | ovf;
                        spec_res <= spec_val;
                        state    <= (div_zero | ovf) ? FINISH : CALC;
                    end
                end
                CALC: begin
                    quo <= {quo[W-2:0], ge};
                    rem <= ge ? diff[W-1:0] : trial[W-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1)) state <= FINISH;
                end
                FINISH: begin
                    if (special)     Result <= spec_res;
                    else if (is_rem) Result <= r_fix;
                    else             Result <= q_fix;
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
